// File: rtl/axi_rd_arb_pkg.sv
// Shared constants, FSM state type and ARSIZE helper for the AXI read arbiter.
package axi_rd_arb_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_e;

  // AXI beat size code: log2 of the number of bytes per data beat.
  function automatic logic [2:0] arsize_f(input int unsigned data_w);
    int unsigned nbytes;
    logic [2:0]  sz;
    nbytes = data_w / 8;
    sz     = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if ((32'd1 << k) == nbytes) sz = 3'(k);
    end
    return sz;
  endfunction

endpackage

// File: rtl/axi_rd_arb_if.sv
// AXI4 read-address / read-data channel bundle between the arbiter and the TPU AXI port.
interface axi_rd_arb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4
) ();

  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

endinterface

// File: rtl/axi_rd_arb_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int unsigned j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int unsigned off = 0; off < N; off++) begin
      j = (32'(ptr) + off) % N;
      if (!any && eligible[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/axi_rd_arb.sv
// Shares one AXI4 AR/R channel pair between NUM_REQ requesters; ARID = requester index.
// Define AXI_RD_ARB_FIXED_PRIO_EN for fixed priority (lowest eligible index wins).
module axi_rd_arb
  import axi_rd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_vld,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]      req_len,
  output logic [NUM_REQ-1:0]        req_rdy,
  output logic [NUM_REQ-1:0]        rsp_vld,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_last,
  output logic                      rsp_err,
  input  logic [NUM_REQ-1:0]        rsp_rdy,
  axi_rd_arb_if.master              axi,
  output logic                      idle
);

  localparam int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W    = $clog2(MAX_OUTST + 1);
  localparam logic [2:0]  ARSIZE_C = arsize_f(DATA_W);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic              arvalid_q, arvalid_d;
  logic [CNT_W-1:0]  cnt_q [NUM_REQ];
  logic [CNT_W-1:0]  cnt_d [NUM_REQ];

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [ADDR_W-1:0]  sel_addr;
  logic [7:0]         sel_len;
  logic [NUM_REQ-1:0] rid_oh;
  logic               rid_ok;
  logic               ar_hs;
  logic               r_last_hs;
  logic [NUM_REQ-1:0] inc_v, dec_v;
  logic               cnt_zero;

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_vld[i] && (cnt_q[i] < CNT_W'(MAX_OUTST));
    end
  end

  // In the fixed-priority build ptr_q never leaves 0, so the picker degenerates.
  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .eligible (elig),
    .ptr      (ptr_q),
    .grant    (pick_oh),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_len  = req_len[i*8 +: 8];
      end
    end
  end

  assign ar_hs = arvalid_q && axi.ARREADY;

  always_comb begin
    req_rdy = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_rdy[i] = ar_hs && (gnt_q == IDX_W'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    len_d     = len_q;
    arvalid_d = arvalid_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d     = pick_idx;
          addr_d    = sel_addr;
          len_d     = sel_len;
          arvalid_d = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (axi.ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = IDLE;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
          ptr_d     = '0;
`else
          ptr_d     = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // R routing is purely combinational; unknown IDs are sunk with RREADY=1.
  always_comb begin
    rid_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rid_oh[i] = (axi.RID == ID_W'(i));
    end
  end

  assign rid_ok     = |rid_oh;
  assign rsp_vld    = axi.RVALID ? rid_oh : '0;
  assign axi.RREADY = axi.RVALID && (rid_ok ? |(rid_oh & rsp_rdy) : 1'b1);
  assign rsp_data   = axi.RVALID ? axi.RDATA : '0;
  assign rsp_last   = axi.RVALID && axi.RLAST;
  assign rsp_err    = axi.RVALID && (axi.RRESP != AXI_RESP_OKAY);
  assign r_last_hs  = axi.RVALID && axi.RREADY && axi.RLAST;

  always_comb begin
    inc_v    = '0;
    dec_v    = '0;
    cnt_zero = 1'b1;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      inc_v[i] = req_rdy[i];
      dec_v[i] = r_last_hs && rid_oh[i] && (cnt_q[i] != '0);
      cnt_d[i] = cnt_q[i];
      if (inc_v[i] && !dec_v[i]) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (dec_v[i] && !inc_v[i]) cnt_d[i] = cnt_q[i] - CNT_W'(1);
      if (cnt_q[i] != '0) cnt_zero = 1'b0;
    end
  end

  assign idle = (state_q == IDLE) && !(|req_vld) && cnt_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      arvalid_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      arvalid_q <= arvalid_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign axi.ARID    = ID_W'(gnt_q);
  assign axi.ARADDR  = addr_q;
  assign axi.ARLEN   = len_q;
  assign axi.ARSIZE  = ARSIZE_C;
  assign axi.ARBURST = AXI_BURST_INCR;
  assign axi.ARVALID = arvalid_q;

endmodule
